// File: rtl/player_move_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// player_move_ctrl_pkg
//   Shared definitions for the player movement controller:
//   - checker direction codes (MOVE_*)
//   - screen and player geometry, used to derive the position limits
//   - FSM state encoding, also driven out on state_dbg for LEDR debug
//   - step_pos(): saturating +/-1 position step
// ---------------------------------------------------------------------------
package player_move_ctrl_pkg;

    // Horizontal codes on chk_l_r
    localparam logic [1:0] MOVE_NONE  = 2'd0;
    localparam logic [1:0] MOVE_RIGHT = 2'd1;
    localparam logic [1:0] MOVE_LEFT  = 2'd2;
    // Vertical codes on chk_u_d. DOWN grows y and UP shrinks it, so DOWN shares
    // the "increment" code with RIGHT and UP shares the "decrement" code with LEFT.
    localparam logic [1:0] MOVE_DOWN  = 2'd1;
    localparam logic [1:0] MOVE_UP    = 2'd2;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PLAYER_W = 20;
    localparam int PLAYER_H = 20;

    typedef enum logic [2:0] {
        ST_WAIT_TICK = 3'd0,
        ST_SAMPLE    = 3'd1,
        ST_START_CHK = 3'd2,
        ST_WAIT_CHK  = 3'd3,
        ST_APPLY     = 3'd4
    } move_state_e;

    // Code 1 steps up, code 2 steps down; the result never leaves 0..max_pos.
    function automatic logic [9:0] step_pos(input logic [9:0] pos,
                                            input logic [1:0] dir,
                                            input logic [9:0] max_pos);
        logic [9:0] nxt;
        nxt = pos;
        if (dir == 2'd1 && pos < max_pos)
            nxt = pos + 10'd1;
        else if (dir == 2'd2 && pos != 10'd0)
            nxt = pos - 10'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/player_move_ctrl_rate_tick_gen.sv
// ---------------------------------------------------------------------------
// player_move_ctrl_rate_tick_gen
//   Free-running counter 0..PERIOD-1 that raises a one-cycle tick each time it
//   wraps. It is never restarted by its user, so the tick rate stays exact.
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   tick  out  one-cycle pulse, once every PERIOD cycles
// ---------------------------------------------------------------------------
module player_move_ctrl_rate_tick_gen #(
    parameter int PERIOD = 500_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// ---------------------------------------------------------------------------
// player_move_ctrl
//   Runs one player-movement step per update tick: samples the direction
//   buttons, asks the collision checker (move_limiter) whether the move is
//   legal, then applies a saturating +/-1 x/y update. A watchdog bounds the
//   checker wait and a sticky flag records ticks that arrive while the
//   previous one is still pending.
//
// Configuration
//   MOVE_VSYNC_EN  defined:   vsync port exists, tick = synchronised falling
//                             edge of vsync (one move per frame)
//                  undefined: tick from a CLK_HZ/UPDATE_HZ counter
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   left, right, up      debounced direction requests
//   flip_vert            1: forward = UP, 0: forward = DOWN
//   chk_start            checker start level (held through the wait)
//   chk_l_r, chk_u_d     direction under check (stable while chk_start=1)
//   chk_done, chk_valid  checker result; chk_valid qualified by chk_done
//   chk_clr              one-cycle checker clear pulse (1 during reset)
//   x_pos, y_pos         player position
//   busy                 high in every state except WAIT_TICK
//   timeout_err          sticky, watchdog fired
//   overrun_err          sticky, tick arrived with a tick already pending
//   state_dbg            current FSM state encoding
//   vsync                active-low VGA vsync (MOVE_VSYNC_EN only)
//
// Checker handshake: chk_start rises with chk_l_r/chk_u_d already stable and
// all three hold until the controller sees chk_done=1 for one cycle (or the
// watchdog fires); chk_valid is only looked at in that chk_done cycle. The
// controller then drops chk_start and pulses chk_clr for one cycle.
// ---------------------------------------------------------------------------
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int UPDATE_HZ   = 100,
    parameter int X_INIT      = 310,
    parameter int Y_INIT      = 230,
    parameter int X_MAX       = SCREEN_W - PLAYER_W,
    parameter int Y_MAX       = SCREEN_H - PLAYER_H,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       flip_vert,
    output logic       chk_start,
    output logic [1:0] chk_l_r,
    output logic [1:0] chk_u_d,
    input  logic       chk_done,
    input  logic       chk_valid,
    output logic       chk_clr,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       busy,
    output logic       timeout_err,
    output logic       overrun_err,
    output logic [2:0] state_dbg
`ifdef MOVE_VSYNC_EN
    ,
    input  logic       vsync
`endif
);

    localparam logic [9:0] X_INIT_L = 10'(X_INIT);
    localparam logic [9:0] Y_INIT_L = 10'(Y_INIT);
    localparam logic [9:0] X_MAX_L  = 10'(X_MAX);
    localparam logic [9:0] Y_MAX_L  = 10'(Y_MAX);
    localparam int         WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic            tick;
    logic            tick_pend;
    logic            enter_sample;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_fire;
    move_state_e     state_q, state_d;
    logic            chk_start_d, chk_clr_d;

    // ------------------------------------------------------------- tick source
`ifdef MOVE_VSYNC_EN
    // Two synchroniser flops plus one history flop; idle level of vsync is 1.
    logic [2:0] vs_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vs_sync <= 3'b111;
        else     vs_sync <= {vs_sync[1:0], vsync};
    end

    assign tick = vs_sync[2] & ~vs_sync[1];
`else
    player_move_ctrl_rate_tick_gen #(
        .PERIOD(CLK_HZ / UPDATE_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );
`endif

    // ----------------------------------------------------- tick pending/overrun
    // A tick that lands while one is already pending is dropped, not queued;
    // it only sets the sticky overrun flag.
    assign enter_sample = (state_q == ST_WAIT_TICK) && tick_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_pend   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (tick && tick_pend)
                overrun_err <= 1'b1;
            if (enter_sample)
                tick_pend <= 1'b0;
            else if (tick)
                tick_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------ FSM register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT_TICK;
        else     state_q <= state_d;
    end

    // --------------------------------------------------------- FSM next state
    assign wd_fire = (wd_cnt == WD_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_TICK: if (tick_pend) state_d = ST_SAMPLE;
            ST_SAMPLE:    state_d = ST_START_CHK;
            ST_START_CHK: state_d = ST_WAIT_CHK;
            ST_WAIT_CHK:  if (chk_done || wd_fire) state_d = ST_APPLY;
            ST_APPLY:     state_d = ST_WAIT_TICK;
            default:      state_d = ST_WAIT_TICK;
        endcase
    end

    // ------------------------------------------------------------ FSM outputs
    // chk_start/chk_clr are registered from the next state so they are
    // glitch-free and chk_clr can hold its reset value of 1.
    always_comb begin
        chk_start_d = 1'b0;
        chk_clr_d   = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_WAIT_TICK: busy = 1'b0;
            ST_SAMPLE, ST_START_CHK, ST_WAIT_CHK, ST_APPLY: ;
            default:      chk_clr_d = 1'b1;  // recover from a corrupt encoding
        endcase
        if (state_d == ST_WAIT_CHK) chk_start_d = 1'b1;
        if (state_d == ST_APPLY)    chk_clr_d   = 1'b1;
    end

    assign state_dbg = state_q;

    // --------------------------------------------------------------- datapath
    // The position step is taken on the edge that leaves WAIT_CHK, so the
    // result is visible during APPLY while chk_clr pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pos       <= X_INIT_L;
            y_pos       <= Y_INIT_L;
            chk_start   <= 1'b0;
            chk_clr     <= 1'b1;
            chk_l_r     <= MOVE_NONE;
            chk_u_d     <= MOVE_NONE;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            chk_start <= chk_start_d;
            chk_clr   <= chk_clr_d;

            if (state_q == ST_SAMPLE) begin
                if (left && !right)      chk_l_r <= MOVE_LEFT;
                else if (right && !left) chk_l_r <= MOVE_RIGHT;
                else                     chk_l_r <= MOVE_NONE;
                chk_u_d <= up ? (flip_vert ? MOVE_UP : MOVE_DOWN) : MOVE_NONE;
            end

            if (state_q == ST_START_CHK)
                wd_cnt <= '0;
            else if (state_q == ST_WAIT_CHK)
                wd_cnt <= wd_cnt + WD_W'(1);

            if (state_q == ST_WAIT_CHK) begin
                if (chk_done) begin          // chk_done wins over the watchdog
                    if (chk_valid) begin
                        x_pos <= step_pos(x_pos, chk_l_r, X_MAX_L);
                        y_pos <= step_pos(y_pos, chk_u_d, Y_MAX_L);
                    end
                end else if (wd_fire) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
module tb_player_move_ctrl;

    localparam int PERIOD  = 100;
    localparam int CLK_HZ  = 10_000;
    localparam int UPD_HZ  = 100;
    localparam int XI      = 310;
    localparam int YI      = 230;
    localparam int XM      = 320;
    localparam int YM      = 240;
    localparam int TMO     = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, flip_vert = 1'b0;
    logic       chk_done = 1'b0, chk_valid = 1'b0;
    logic       chk_start, chk_clr, busy, timeout_err, overrun_err;
    logic [1:0] chk_l_r, chk_u_d;
    logic [9:0] x_pos, y_pos;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int mx    = XI;
    int my    = YI;
    int start_rises = 0;
    logic start_prev = 1'b0;

    player_move_ctrl #(
        .CLK_HZ(CLK_HZ), .UPDATE_HZ(UPD_HZ), .X_INIT(XI), .Y_INIT(YI),
        .X_MAX(XM), .Y_MAX(YM), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .up(up),
        .flip_vert(flip_vert), .chk_start(chk_start), .chk_l_r(chk_l_r),
        .chk_u_d(chk_u_d), .chk_done(chk_done), .chk_valid(chk_valid),
        .chk_clr(chk_clr), .x_pos(x_pos), .y_pos(y_pos), .busy(busy),
        .timeout_err(timeout_err), .overrun_err(overrun_err),
        .state_dbg(state_dbg)
    );

    // ---------------------------------------------------------- clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not end, bad=%0d", bad);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (chk_start && !start_prev) start_rises++;
        start_prev = chk_start;
    end

    // ------------------------------------------------------------ scoreboard
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    // Reference rules: conflicting horizontal buttons cancel; forward is up on
    // screen (y shrinks) when flipped, down otherwise.
    task automatic ref_move(input logic l, input logic r, input logic u, input logic fv,
                            output logic [1:0] e_lr, output logic [1:0] e_ud,
                            output int dx, output int dy);
        dx = 0;
        if (l && !r) dx = -1;
        if (r && !l) dx = 1;
        dy = u ? (fv ? -1 : 1) : 0;
        e_lr = (dx > 0) ? 2'd1 : (dx < 0) ? 2'd2 : 2'd0;
        e_ud = (dy > 0) ? 2'd1 : (dy < 0) ? 2'd2 : 2'd0;
    endtask

    // ---------------------------------------------------------------- driver
    task automatic do_move(input string nm, input logic l, input logic r,
                           input logic u, input logic fv,
                           input logic [1:0] e_lr, input logic [1:0] e_ud,
                           input int dx, input int dy, input int delay,
                           input logic vld, input logic respond);
        int n;
        left = l; right = r; up = u; flip_vert = fv;
        n = 0;
        while (!chk_start && n < 3 * PERIOD + 20) begin
            @(negedge clk);
            n++;
        end
        if (!chk_start) begin
            check({nm, "_start_seen"}, 32'd0, 32'd1);
            return;
        end
        check({nm, "_lr"}, 32'(chk_l_r), 32'(e_lr));
        check({nm, "_ud"}, 32'(chk_u_d), 32'(e_ud));
        if (respond) begin
            repeat (delay) @(negedge clk);
            if (delay > 0) check({nm, "_hold"}, 32'(chk_start), 32'd1);
            chk_done = 1'b1;
            chk_valid = vld;
            @(negedge clk);
            chk_done = 1'b0;
            chk_valid = 1'b0;
            if (vld) begin
                mx = clamp(mx + dx, XM);
                my = clamp(my + dy, YM);
            end
        end
        n = 0;
        while (busy && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_idle"}, 32'(busy), 32'd0);
        check({nm, "_x"}, 32'(x_pos), 32'(mx));
        check({nm, "_y"}, 32'(y_pos), 32'(my));
    endtask

    typedef struct {
        logic l, r, u, fv, vld;
        int   delay;
        logic [1:0] lr, ud;
        int   dx, dy;
    } vec_t;

    vec_t vecs[8];

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [1:0] e_lr, e_ud;
        int dx, dy, n, rises0;
        logic l, r, u, fv, vld;

        vecs[0] = '{l:0, r:1, u:0, fv:0, vld:1, delay:0,  lr:1, ud:0, dx: 1, dy: 0};
        vecs[1] = '{l:1, r:0, u:0, fv:0, vld:1, delay:2,  lr:2, ud:0, dx:-1, dy: 0};
        vecs[2] = '{l:1, r:1, u:1, fv:1, vld:1, delay:0,  lr:0, ud:2, dx: 0, dy:-1};
        vecs[3] = '{l:0, r:0, u:1, fv:0, vld:1, delay:3,  lr:0, ud:1, dx: 0, dy: 1};
        vecs[4] = '{l:0, r:1, u:1, fv:1, vld:0, delay:1,  lr:1, ud:2, dx: 1, dy:-1};
        vecs[5] = '{l:0, r:0, u:0, fv:1, vld:1, delay:0,  lr:0, ud:0, dx: 0, dy: 0};
        vecs[6] = '{l:1, r:0, u:1, fv:0, vld:1, delay:5,  lr:2, ud:1, dx:-1, dy: 1};
        vecs[7] = '{l:0, r:1, u:0, fv:1, vld:1, delay:10, lr:1, ud:0, dx: 1, dy: 0};

        // Reset values
        right = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x_pos), XI);
        check("rst_y", 32'(y_pos), YI);
        check("rst_busy", 32'(busy), 0);
        check("rst_clr", 32'(chk_clr), 1);
        check("rst_start", 32'(chk_start), 0);
        check("rst_lr", 32'(chk_l_r), 0);
        check("rst_ud", 32'(chk_u_d), 0);
        check("rst_tmo", 32'(timeout_err), 0);
        check("rst_ovr", 32'(overrun_err), 0);
        check("rst_state", 32'(state_dbg), 0);
        rises0 = start_rises;
        rst = 1'b0;

        // First tick, right move, exact edge timing
        n = 0;
        while (!busy && n < 3 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        check("t_busy_rise", 32'(busy), 1);
        check("t_n1_start", 32'(chk_start), 0);
        check("t_n1_clr", 32'(chk_clr), 0);
        @(negedge clk);
        check("t_n2_start", 32'(chk_start), 0);
        @(negedge clk);
        check("t_n3_start", 32'(chk_start), 1);
        check("t_n3_lr", 32'(chk_l_r), 1);
        check("t_n3_x", 32'(x_pos), 310);
        chk_done = 1'b1;
        chk_valid = 1'b1;
        @(negedge clk);
        chk_done = 1'b0;
        chk_valid = 1'b0;
        check("t_n4_x", 32'(x_pos), 311);
        check("t_n4_clr", 32'(chk_clr), 1);
        check("t_n4_start", 32'(chk_start), 0);
        @(negedge clk);
        check("t_n5_clr", 32'(chk_clr), 0);
        check("t_n5_busy", 32'(busy), 0);
        check("t_one_rise", 32'(start_rises - rises0), 1);
        mx = 311;

        // Table vectors
        for (int i = 0; i < 8; i++)
            do_move($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].fv,
                    vecs[i].lr, vecs[i].ud, vecs[i].dx, vecs[i].dy,
                    vecs[i].delay, vecs[i].vld, 1'b1);

        // Random moves against the reference rules
        for (int i = 0; i < 60; i++) begin
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            fv = 1'($urandom_range(0, 1));
            vld = 1'($urandom_range(0, 3) != 0);
            ref_move(l, r, u, fv, e_lr, e_ud, dx, dy);
            do_move($sformatf("rnd%0d", i), l, r, u, fv, e_lr, e_ud, dx, dy,
                    int'($urandom_range(0, 15)), vld, 1'b1);
        end
        check("rnd_ovr", 32'(overrun_err), 0);
        check("rnd_tmo", 32'(timeout_err), 0);

        // Saturation at X_MAX, Y_MAX and 0
        n = 0;
        while ((mx < XM || n < 2) && n < 200) begin
            do_move("sat_r", 0, 1, 0, 0, 2'd1, 2'd0, 1, 0, 0, 1'b1, 1'b1);
            if (mx == XM) n++;
        end
        check("sat_xmax", 32'(x_pos), XM);
        n = 0;
        while ((my < YM || n < 2) && n < 200) begin
            do_move("sat_d", 0, 0, 1, 0, 2'd0, 2'd1, 0, 1, 0, 1'b1, 1'b1);
            if (my == YM) n++;
        end
        check("sat_ymax", 32'(y_pos), YM);
        n = 0;
        while ((mx > 0 || n < 2) && n < 400) begin
            do_move("sat_l", 1, 0, 0, 0, 2'd2, 2'd0, -1, 0, 0, 1'b1, 1'b1);
            if (mx == 0) n++;
        end
        check("sat_xzero", 32'(x_pos), 0);

        // Checker stalls for more than two tick periods: overrun
        do_move("stall", 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2 * PERIOD + 50, 1'b1, 1'b1);
        check("stall_ovr", 32'(overrun_err), 1);
        check("stall_tmo", 32'(timeout_err), 0);
        do_move("after_stall", 0, 1, 0, 0, 2'd1, 2'd0, 1, 0, 0, 1'b1, 1'b1);

        // Checker never answers: watchdog, no move, then normal resume
        do_move("tmo", 0, 1, 0, 0, 2'd1, 2'd0, 1, 0, 0, 1'b1, 1'b0);
        check("tmo_flag", 32'(timeout_err), 1);
        do_move("tmo_resume", 0, 1, 0, 0, 2'd1, 2'd0, 1, 0, 0, 1'b1, 1'b1);

        // Reset in the middle of WAIT_CHK discards the move
        left = 1'b1; right = 1'b0; up = 1'b1; flip_vert = 1'b1;
        n = 0;
        while (!chk_start && n < 3 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        check("mid_start", 32'(chk_start), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_x", 32'(x_pos), XI);
        check("mid_y", 32'(y_pos), YI);
        check("mid_start_clr", 32'(chk_start), 0);
        check("mid_lr", 32'(chk_l_r), 0);
        check("mid_ud", 32'(chk_u_d), 0);
        check("mid_clr", 32'(chk_clr), 1);
        check("mid_busy", 32'(busy), 0);
        check("mid_tmo", 32'(timeout_err), 0);
        check("mid_ovr", 32'(overrun_err), 0);
        mx = XI;
        my = YI;
        @(negedge clk);
        rst = 1'b0;
        do_move("post_rst", 1, 0, 1, 1, 2'd2, 2'd2, -1, -1, 1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
